// File: rtl/unit_propagation_engine.sv
// unit_propagation_engine
//   Constraint-propagation front end for the sudoku backtracking controller.
//   Latches a candidate grid and sweeps every row, column and box, one unit
//   per clock. Each unit gets naked-single elimination and hidden-single
//   assignment. Full passes repeat until the grid is solved, stops changing,
//   contradicts itself, or reaches the pass limit.
//
//   Build option: define ELIM_COUNT_EN to count removed candidate bits on
//   elim_count_out. Without it, the popcount logic is not built and
//   elim_count_out is tied to 0.
//
// Ports
//   clk_in          clock, all state updates on the rising edge
//   reset_n_in      asynchronous active-low reset
//   start_in        start request, sampled only in IDLE
//   pvr_in          candidate grid; cell i=r*G+c at [i*G +: G], bit v-1 = value v
//   busy_out        high while scanning or checking
//   done_out        one-cycle pulse, result valid
//   status_out      00 SOLVED, 01 STUCK, 10 TIMEOUT, 11 CONTRADICTION
//   pvr_out         working grid register, final grid after done
//   pass_count_out  completed passes, saturating at 255
//   elim_count_out  removed candidate bits, saturating
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start_in
// SCAN   | read-modify-write of unit u (rows, then columns, then boxes)
// CHECK  | end of pass: count it and decide whether to stop or rescan
// DONE   | one-cycle result pulse, then back to IDLE
module unit_propagation_engine #(
   parameter int BOX_SIZE   = 3,
   parameter int MAX_PASSES = 16,
   parameter int CNT_W      = 16,
   localparam int G         = BOX_SIZE * BOX_SIZE,
   localparam int W         = G * G * G
) (
   input  logic             clk_in,
   input  logic             reset_n_in,
   input  logic             start_in,
   input  logic [W-1:0]     pvr_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [1:0]       status_out,
   output logic [W-1:0]     pvr_out,
   output logic [7:0]       pass_count_out,
   output logic [CNT_W-1:0] elim_count_out
);

   localparam int N  = G * G;
   localparam int U  = 3 * G;
   localparam int UW = $clog2(U);

   localparam logic [1:0] ST_SOLVED  = 2'b00;
   localparam logic [1:0] ST_STUCK   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_CONTRA  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_CHECK,
      S_DONE
   } state_t;

   state_t          state, state_next;
   logic [W-1:0]    pvr_q;
   logic [UW-1:0]   u_q;
   logic [7:0]      pass_q;
   logic [1:0]      status_q;
   logic            changed_q;

   logic [G-1:0]    cell_old [G];
   logic [G-1:0]    cell_new [G];
   int              cidx [G];
   logic [W-1:0]    pvr_scan;
   logic            unit_changed;
   logic            contra;
   logic            all_solved;
   logic [7:0]      pass_inc;
   logic            last_unit;

   // Grid cell index of member k of unit u.
   function automatic int cell_index(input logic [UW-1:0] unit, input int k);
      int un, b, r, c;
      un = int'(32'(unit));
      b  = 0;
      if (un < G) begin
         r = un;
         c = k;
      end else if (un < 2 * G) begin
         r = k;
         c = un - G;
      end else begin
         b = un - 2 * G;
         r = BOX_SIZE * (b / BOX_SIZE) + k / BOX_SIZE;
         c = BOX_SIZE * (b % BOX_SIZE) + k % BOX_SIZE;
      end
      return r * G + c;
   endfunction

   // Unit read-modify-write. Naked and hidden singles both see only the
   // values read at the start of the cycle; hidden wins for its cell.
   always_comb begin
      logic [G-1:0] seen, multi, uniq, mask, hid, any_new;
      seen         = '0;
      multi        = '0;
      any_new      = '0;
      contra       = 1'b0;
      unit_changed = 1'b0;
      pvr_scan     = pvr_q;
      for (int k = 0; k < G; k++) begin
         cidx[k]     = cell_index(u_q, k);
         cell_old[k] = pvr_q[cidx[k]*G +: G];
      end
      for (int k = 0; k < G; k++) begin
         multi = multi | (seen & cell_old[k]);
         seen  = seen | cell_old[k];
      end
      uniq = seen & ~multi;
      for (int k = 0; k < G; k++) begin
         mask = '0;
         for (int j = 0; j < G; j++) begin
            if (j != k && $onehot(cell_old[j])) mask = mask | cell_old[j];
         end
         cell_new[k] = cell_old[k] & ~mask;
         // Two hidden values in one cell: highest wins, the other value then
         // vanishes from the unit and is reported as a contradiction.
         hid = cell_old[k] & uniq;
         for (int v = 0; v < G; v++) begin
            if (hid[v]) cell_new[k] = G'(1) << v;
         end
         if (cell_new[k] == '0) contra = 1'b1;
         if (cell_new[k] != cell_old[k]) unit_changed = 1'b1;
         any_new = any_new | cell_new[k];
         pvr_scan[cidx[k]*G +: G] = cell_new[k];
      end
      if (any_new != {G{1'b1}}) contra = 1'b1;
   end

   always_comb begin
      all_solved = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (!$onehot(pvr_q[i*G +: G])) all_solved = 1'b0;
      end
   end

   assign pass_inc  = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
   assign last_unit = (u_q == UW'(U - 1));

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state <= S_IDLE;
      else             state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start_in) state_next = S_SCAN;
         S_SCAN: begin
            if (contra)         state_next = S_DONE;
            else if (last_unit) state_next = S_CHECK;
         end
         S_CHECK: begin
            if (all_solved || !changed_q || pass_inc == 8'(MAX_PASSES))
               state_next = S_DONE;
            else
               state_next = S_SCAN;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         pvr_q     <= '0;
         u_q       <= '0;
         pass_q    <= '0;
         status_q  <= ST_SOLVED;
         changed_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_in) begin
                  pvr_q     <= pvr_in;
                  u_q       <= '0;
                  pass_q    <= '0;
                  status_q  <= ST_SOLVED;
                  changed_q <= 1'b0;
               end
            end
            S_SCAN: begin
               pvr_q <= pvr_scan;
               if (unit_changed) changed_q <= 1'b1;
               if (contra)         status_q <= ST_CONTRA;
               else if (last_unit) u_q <= '0;
               else                u_q <= u_q + 1'b1;
            end
            S_CHECK: begin
               pass_q <= pass_inc;
               if (all_solved)                        status_q <= ST_SOLVED;
               else if (!changed_q)                   status_q <= ST_STUCK;
               else if (pass_inc == 8'(MAX_PASSES))   status_q <= ST_TIMEOUT;
               else begin
                  changed_q <= 1'b0;
                  u_q       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ELIM_COUNT_EN
   localparam int PCW = $clog2(N + 1);

   logic [CNT_W-1:0] elim_q;
   logic [PCW-1:0]   removed;
   logic [CNT_W:0]   elim_sum;

   always_comb begin
      removed = '0;
      for (int k = 0; k < G; k++) begin
         for (int v = 0; v < G; v++) begin
            removed = removed + PCW'(cell_old[k][v] & ~cell_new[k][v]);
         end
      end
   end

   assign elim_sum = {1'b0, elim_q} + (CNT_W + 1)'(removed);

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         elim_q <= '0;
      end else if (state == S_IDLE && start_in) begin
         elim_q <= '0;
      end else if (state == S_SCAN) begin
         elim_q <= elim_sum[CNT_W] ? {CNT_W{1'b1}} : elim_sum[CNT_W-1:0];
      end
   end

   assign elim_count_out = elim_q;
`else
   assign elim_count_out = '0;
`endif

   assign busy_out       = (state == S_SCAN) || (state == S_CHECK);
   assign done_out       = (state == S_DONE);
   assign status_out     = status_q;
   assign pvr_out        = pvr_q;
   assign pass_count_out = pass_q;

endmodule

// File: tb/tb_unit_propagation_engine.sv
module tb_unit_propagation_engine;

   localparam int W = 729;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   pvr_in = '0;
   logic           busy, done;
   logic [1:0]     status;
   logic [W-1:0]   pvr_out;
   logic [7:0]     pass_count;
   logic [15:0]    elim_count;

   int checks = 0;
   int failures = 0;

   unit_propagation_engine dut (
      .clk_in(clk),
      .reset_n_in(rst_n),
      .start_in(start),
      .pvr_in(pvr_in),
      .busy_out(busy),
      .done_out(done),
      .status_out(status),
      .pvr_out(pvr_out),
      .pass_count_out(pass_count),
      .elim_count_out(elim_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] put(input logic [W-1:0] g, input int r, input int c,
                                         input logic [8:0] v);
      g[(r*9+c)*9 +: 9] = v;
      return g;
   endfunction

   function automatic logic [W-1:0] solved_grid();
      logic [W-1:0] g;
      int val;
      g = '0;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++) begin
            val = ((r*3 + r/3 + c) % 9) + 1;
            g = put(g, r, c, 9'(1) << (val - 1));
         end
      return g;
   endfunction

   function automatic logic [15:0] exp_elim(input int n);
`ifdef ELIM_COUNT_EN
      return 16'(n);
`else
      return 16'(0 * n);
`endif
   endfunction

   // Launch a run, optionally pulse start mid-run with a different grid.
   // lat = index of the first cycle after the start edge with done high
   // (cycle k ends at start edge + k); -1 if done never arrives.
   task automatic run(input logic [W-1:0] grid, input int glitch_at, output int lat);
      lat = -1;
      @(negedge clk);
      pvr_in = grid;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == glitch_at) begin
            start  = 1'b1;
            pvr_in = {W{1'b1}};
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (status !== 2'b00) begin failures++; $display("FAIL reset_status got=%b exp=00", status); end
      checks++; if (pvr_out !== '0) begin failures++; $display("FAIL reset_pvr got nonzero exp=0"); end
      checks++; if (pass_count !== 8'd0) begin failures++; $display("FAIL reset_pass got=%0d exp=0", pass_count); end
      checks++; if (elim_count !== 16'd0) begin failures++; $display("FAIL reset_elim got=%0d exp=0", elim_count); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_solved();
      logic [W-1:0] g;
      int lat;
      g = solved_grid();
      run(g, 0, lat);
      checks++; if (lat !== 29) begin failures++; $display("FAIL solved_latency got=%0d exp=29", lat); end
      checks++; if (status !== 2'b00) begin failures++; $display("FAIL solved_status got=%b exp=00", status); end
      checks++; if (pass_count !== 8'd1) begin failures++; $display("FAIL solved_pass got=%0d exp=1", pass_count); end
      checks++; if (pvr_out !== g) begin failures++; $display("FAIL solved_pvr got=%h exp=%h", pvr_out, g); end
      checks++; if (elim_count !== 16'd0) begin failures++; $display("FAIL solved_elim got=%0d exp=0", elim_count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL solved_busy_in_done got=%b exp=0", busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL solved_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_naked_single();
      logic [W-1:0] g, gi;
      int lat;
      g  = solved_grid();
      gi = put(g, 0, 0, 9'h1FF);
      run(gi, 0, lat);
      checks++; if (lat !== 29) begin failures++; $display("FAIL naked_latency got=%0d exp=29", lat); end
      checks++; if (status !== 2'b00) begin failures++; $display("FAIL naked_status got=%b exp=00", status); end
      checks++; if (pass_count !== 8'd1) begin failures++; $display("FAIL naked_pass got=%0d exp=1", pass_count); end
      checks++; if (pvr_out !== g) begin failures++; $display("FAIL naked_pvr got=%h exp=%h", pvr_out, g); end
      checks++; if (elim_count !== exp_elim(8)) begin failures++; $display("FAIL naked_elim got=%0d exp=%0d", elim_count, exp_elim(8)); end
   endtask

   task automatic test_stuck();
      logic [W-1:0] g;
      int lat;
      g = {W{1'b1}};
      run(g, 0, lat);
      checks++; if (lat !== 29) begin failures++; $display("FAIL stuck_latency got=%0d exp=29", lat); end
      checks++; if (status !== 2'b01) begin failures++; $display("FAIL stuck_status got=%b exp=01", status); end
      checks++; if (pass_count !== 8'd1) begin failures++; $display("FAIL stuck_pass got=%0d exp=1", pass_count); end
      checks++; if (pvr_out !== g) begin failures++; $display("FAIL stuck_pvr got=%h exp=%h", pvr_out, g); end
      checks++; if (elim_count !== 16'd0) begin failures++; $display("FAIL stuck_elim got=%0d exp=0", elim_count); end
   endtask

   task automatic test_contradiction();
      logic [W-1:0] g, e;
      int lat;
      g = put(put({W{1'b1}}, 0, 0, 9'h001), 0, 1, 9'h001);
      e = put(put({W{1'b1}}, 0, 0, 9'h000), 0, 1, 9'h000);
      for (int c = 2; c < 9; c++) e = put(e, 0, c, 9'h1FE);
      run(g, 0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL contra_latency got=%0d exp=2", lat); end
      checks++; if (status !== 2'b11) begin failures++; $display("FAIL contra_status got=%b exp=11", status); end
      checks++; if (pvr_out !== e) begin failures++; $display("FAIL contra_pvr got=%h exp=%h", pvr_out, e); end
      checks++; if (pass_count !== 8'd0) begin failures++; $display("FAIL contra_pass got=%0d exp=0", pass_count); end
      checks++; if (elim_count !== exp_elim(9)) begin failures++; $display("FAIL contra_elim got=%0d exp=%0d", elim_count, exp_elim(9)); end
   endtask

   task automatic test_hidden_single();
      logic [W-1:0] g, e;
      int lat;
      g = {W{1'b1}};
      for (int c = 1; c < 9; c++) g = put(g, 0, c, 9'h1EF);
      e = put(g, 0, 0, 9'h010);
      for (int r = 1; r < 9; r++) e = put(e, r, 0, 9'h1EF);
      e = put(e, 1, 1, 9'h1EF);
      e = put(e, 1, 2, 9'h1EF);
      e = put(e, 2, 1, 9'h1EF);
      e = put(e, 2, 2, 9'h1EF);
      run(g, 0, lat);
      checks++; if (lat !== 57) begin failures++; $display("FAIL hidden_latency got=%0d exp=57", lat); end
      checks++; if (status !== 2'b01) begin failures++; $display("FAIL hidden_status got=%b exp=01", status); end
      checks++; if (pass_count !== 8'd2) begin failures++; $display("FAIL hidden_pass got=%0d exp=2", pass_count); end
      checks++; if (pvr_out !== e) begin failures++; $display("FAIL hidden_pvr got=%h exp=%h", pvr_out, e); end
      checks++; if (elim_count !== exp_elim(20)) begin failures++; $display("FAIL hidden_elim got=%0d exp=%0d", elim_count, exp_elim(20)); end
   endtask

   task automatic test_start_while_busy();
      logic [W-1:0] g, gi;
      int lat;
      g  = solved_grid();
      gi = put(g, 0, 0, 9'h1FF);
      run(gi, 5, lat);
      checks++; if (lat !== 29) begin failures++; $display("FAIL busy_start_latency got=%0d exp=29", lat); end
      checks++; if (status !== 2'b00) begin failures++; $display("FAIL busy_start_status got=%b exp=00", status); end
      checks++; if (pvr_out !== g) begin failures++; $display("FAIL busy_start_pvr got=%h exp=%h", pvr_out, g); end
      checks++; if (elim_count !== exp_elim(8)) begin failures++; $display("FAIL busy_start_elim got=%0d exp=%0d", elim_count, exp_elim(8)); end
   endtask

   task automatic test_reset_mid_run();
      logic saw_done;
      @(negedge clk);
      pvr_in = put(solved_grid(), 0, 0, 9'h1FF);
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
      checks++; if (pvr_out !== '0) begin failures++; $display("FAIL midreset_pvr got nonzero exp=0"); end
      checks++; if (elim_count !== 16'd0 || pass_count !== 8'd0 || status !== 2'b00)
         begin failures++; $display("FAIL midreset_counts got elim=%0d pass=%0d status=%b exp=0", elim_count, pass_count, status); end
      saw_done = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", saw_done); end
   endtask

   initial begin
      test_reset();
      test_solved();
      test_naked_single();
      test_stuck();
      test_contradiction();
      test_hidden_single();
      test_start_while_busy();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
